// File: rtl/plic_lite.sv
// plic_lite: small platform-level interrupt controller.
// Per-source level/edge gateways feed a priority/enable/threshold arbiter.
// Software claims the winning ID by reading the claim register and returns it
// by writing the same ID back (complete).
//
// Register port handshake: we and re are single-cycle strobes with no
// back-pressure. A read at edge c returns data on rdata after edge c (valid for
// the following cycle). If re and we coincide, the read executes and the write
// is dropped.
module plic_lite #(
    parameter int SOURCES   = 8,
    parameter int PRIO_BITS = 3,
    parameter int XLEN      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SOURCES-1:0] irq_src,
    input  logic [9:0]         addr,
    input  logic [XLEN-1:0]    wdata,
    input  logic               we,
    input  logic               re,
    output logic [XLEN-1:0]    rdata,
    output logic               exti
);
    localparam int IDW = 5;

    // Word offsets of the fixed registers
    localparam logic [7:0] W_PENDING   = 8'd32;   // 0x080
    localparam logic [7:0] W_ENABLE    = 8'd64;   // 0x100
    localparam logic [7:0] W_THRESHOLD = 8'd65;   // 0x104
    localparam logic [7:0] W_CLAIM     = 8'd66;   // 0x108
    localparam logic [7:0] W_MODE      = 8'd67;   // 0x10C

    logic [PRIO_BITS-1:0] prio_q [1:SOURCES];
    logic [PRIO_BITS-1:0] prio_d [1:SOURCES];
    logic [SOURCES:1]     enable_q, enable_d;
    logic [SOURCES:1]     mode_q, mode_d;
    logic [PRIO_BITS-1:0] thr_q, thr_d;
    logic [SOURCES:1]     pending_q, pending_d;
    logic [SOURCES:1]     in_flight_q, in_flight_d;
    logic [SOURCES:1]     held_q, held_d;
    logic [SOURCES-1:0]   src_prev_q;
    logic [IDW-1:0]       best_id_q, best_id_d;
    logic [PRIO_BITS-1:0] best_prio_q, best_prio_d;
    logic [XLEN-1:0]      rdata_q, rdata_d;

    logic [7:0]         word;
    logic               wr_en;
    logic               claim_fire;
    logic               cmp_write;
    logic [IDW-1:0]     cmp_id;
    logic [SOURCES-1:0] rise;
    logic               unused_ok;

    assign word       = addr[9:2];
    assign wr_en      = we & ~re;
    assign claim_fire = re && (word == W_CLAIM) && (best_id_q != '0);
    assign cmp_write  = wr_en && (word == W_CLAIM);
    assign cmp_id     = wdata[IDW-1:0];
    assign rise       = irq_src & ~src_prev_q;
    assign unused_ok  = ^{addr[1:0], wdata, best_prio_q};

    // Configuration register writes (priority, enable, threshold, mode)
    always_comb begin
        prio_d   = prio_q;
        enable_d = enable_q;
        thr_d    = thr_q;
        mode_d   = mode_q;
        if (wr_en) begin
            case (word)
                W_ENABLE:    enable_d = wdata[SOURCES:1];
                W_THRESHOLD: thr_d    = wdata[PRIO_BITS-1:0];
                W_MODE:      mode_d   = wdata[SOURCES:1];
                default: begin
                    for (int i = 1; i <= SOURCES; i++) begin
                        if (word == 8'(i)) prio_d[i] = wdata[PRIO_BITS-1:0];
                    end
                end
            endcase
        end
    end

    // Read mux; rdata is registered and returns to 0 when no read is issued
    always_comb begin
        rdata_d = '0;
        if (re) begin
            case (word)
                W_PENDING:   rdata_d = XLEN'({pending_q, 1'b0});
                W_ENABLE:    rdata_d = XLEN'({enable_q, 1'b0});
                W_THRESHOLD: rdata_d = XLEN'(thr_q);
                W_CLAIM:     rdata_d = XLEN'(best_id_q);
                W_MODE:      rdata_d = XLEN'({mode_q, 1'b0});
                default: begin
                    for (int i = 1; i <= SOURCES; i++) begin
                        if (word == 8'(i)) rdata_d = XLEN'(prio_q[i]);
                    end
                end
            endcase
        end
    end

    // Per-source gateways: pending / in_flight / edge_held next state
    always_comb begin
        pending_d   = pending_q;
        in_flight_d = in_flight_q;
        held_d      = held_q;
        for (int i = 1; i <= SOURCES; i++) begin
            logic busy;
            logic claim_i;
            logic cmp_i;
            busy    = pending_q[i] | in_flight_q[i];
            claim_i = claim_fire && (best_id_q == IDW'(i));
            cmp_i   = cmp_write && (cmp_id == IDW'(i)) && in_flight_q[i];
            if (mode_q[i]) begin
                // Edge: a new edge or a held edge raises pending once the
                // source is idle; an edge while busy is remembered once.
                if (!busy && (rise[i-1] || held_q[i])) begin
                    pending_d[i] = 1'b1;
                    held_d[i]    = 1'b0;
                end else if (busy && rise[i-1]) begin
                    held_d[i] = 1'b1;
                end
            end else begin
                if (!busy && irq_src[i-1]) pending_d[i] = 1'b1;
            end
            if (cmp_i) in_flight_d[i] = 1'b0;
            // Claim wins over a same-cycle source event
            if (claim_i) begin
                pending_d[i]   = 1'b0;
                in_flight_d[i] = 1'b1;
                if (mode_q[i] && rise[i-1]) held_d[i] = 1'b1;
            end
        end
        // Switching trigger mode discards any remembered edge
        if (wr_en && (word == W_MODE)) held_d = '0;
    end

    // Arbiter: highest priority above threshold, lowest ID on ties
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int i = 1; i <= SOURCES; i++) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > thr_q)) begin
                if ((best_id_d == '0) || (prio_q[i] > best_prio_d)) begin
                    best_id_d   = IDW'(i);
                    best_prio_d = prio_q[i];
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i <= SOURCES; i++) prio_q[i] <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            thr_q       <= '0;
            pending_q   <= '0;
            in_flight_q <= '0;
            held_q      <= '0;
            src_prev_q  <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            rdata_q     <= '0;
        end else begin
            for (int i = 1; i <= SOURCES; i++) prio_q[i] <= prio_d[i];
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            thr_q       <= thr_d;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
            held_q      <= held_d;
            src_prev_q  <= irq_src;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign exti  = (best_id_q != '0);

endmodule
